// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between the IF and MEM requesters: data-priority
// address arbitration with lock-until-accepted, in-order owner FIFO for returns.
module sram_like_arbiter #(
  parameter int OUTS_DEPTH = 4,
  parameter int OUTS_AW    = 2
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [31:0]       inst_addr,
  input  logic [3:0]        inst_wstrb,
  input  logic [31:0]       inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [31:0]       data_addr,
  input  logic [3:0]        data_wstrb,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,

  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [31:0]       bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata,

  output logic [OUTS_AW:0]  outs_cnt,
  output logic              err_unexp
);

  localparam int CNT_W = OUTS_AW + 1;

  // state     | meaning
  // ST_IDLE   | nothing presented; owner chosen fresh, data side first
  // ST_LOCK_I | IF request presented, waiting for bus_addr_ok
  // ST_LOCK_D | MEM request presented, waiting for bus_addr_ok
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [OUTS_DEPTH-1:0]   owner_mem_q, owner_mem_d;
  logic [OUTS_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [OUTS_AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        outs_cnt_q, outs_cnt_d;
  logic                    err_q, err_d;

  logic sel_data;
  logic owner_req;
  logic full;
  logic empty;
  logic acc;
  logic ret;
  logic head_data;
  logic fld_data;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner select: locked states pin the owner so bus fields stay stable
  always_comb begin
    sel_data = 1'b1;
    unique case (state_q)
      ST_IDLE:   sel_data = data_req || !inst_req;
      ST_LOCK_I: sel_data = 1'b0;
      ST_LOCK_D: sel_data = 1'b1;
      default:   sel_data = 1'b1;
    endcase
  end

  assign owner_req = sel_data ? data_req : inst_req;
  assign full      = (outs_cnt_q == CNT_W'(OUTS_DEPTH));
  assign empty     = (outs_cnt_q == '0);
  assign head_data = owner_mem_q[rd_ptr_q];

  // Gating with reset keeps the bus and all handshakes quiet while held in reset
  assign bus_req = reset && !full && owner_req;
  assign acc     = bus_req && bus_addr_ok;
  assign ret     = reset && bus_data_ok && !empty;

  // Next-state
  always_comb begin
    state_d = ST_IDLE;
    if (bus_req && !acc) begin
      state_d = sel_data ? ST_LOCK_D : ST_LOCK_I;
    end
  end

  // Outputs
  always_comb begin
    fld_data     = sel_data || !bus_req;
    bus_wr       = fld_data ? data_wr    : inst_wr;
    bus_size     = fld_data ? data_size  : inst_size;
    bus_addr     = fld_data ? data_addr  : inst_addr;
    bus_wstrb    = fld_data ? data_wstrb : inst_wstrb;
    bus_wdata    = fld_data ? data_wdata : inst_wdata;

    inst_addr_ok = acc && !sel_data;
    data_addr_ok = acc && sel_data;

    inst_data_ok = ret && !head_data;
    data_data_ok = ret && head_data;
    inst_rdata   = (!empty && !head_data) ? bus_rdata : '0;
    data_rdata   = (!empty && head_data)  ? bus_rdata : '0;
  end

  // Owner FIFO; pop reads the pre-push head so a new entry cannot retire itself
  always_comb begin
    owner_mem_d = owner_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    outs_cnt_d  = outs_cnt_q;
    if (acc) begin
      owner_mem_d[wr_ptr_q] = sel_data;
      wr_ptr_d              = wr_ptr_q + OUTS_AW'(1);
    end
    if (ret) begin
      rd_ptr_d = rd_ptr_q + OUTS_AW'(1);
    end
    unique case ({acc, ret})
      2'b10:   outs_cnt_d = outs_cnt_q + CNT_W'(1);
      2'b01:   outs_cnt_d = outs_cnt_q - CNT_W'(1);
      default: outs_cnt_d = outs_cnt_q;
    endcase
  end

  always_comb begin
    err_d = err_q || (bus_data_ok && empty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_mem_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      outs_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      owner_mem_q <= owner_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      outs_cnt_q  <= outs_cnt_d;
      err_q       <= err_d;
    end
  end

  assign outs_cnt  = outs_cnt_q;
  assign err_unexp = err_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: directed scenarios then random traffic,
// checked against a queue-based model of the arbitration and return-ordering rules.
module tb_sram_like_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic [2:0]  outs_cnt;
  logic        err_unexp;

  sram_like_arbiter #(.OUTS_DEPTH(4), .OUTS_AW(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .outs_cnt(outs_cnt), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iaok, daok, breq, bwr, err;
    logic [1:0]  bsize;
    logic [3:0]  bwstrb;
    logic [31:0] baddr, bwdata;
    int          cnt;
  } exp_t;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } ret_t;

  exp_t exp_q[$];
  ret_t ret_q[$];

  // Reference model: list of outstanding owners (1 = data), sticky owner, error flag
  bit   oq[$];
  int   lock_who;      // 0 none, 1 IF, 2 MEM
  logic err_m;

  int n_cmp = 0;
  int n_bad = 0;

  // Held per-side request attributes
  logic [31:0] i_wdata_h;
  logic        d_wr_h;
  logic [1:0]  d_size_h;
  logic [3:0]  d_wstrb_h;
  logic [31:0] d_wdata_h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit ireq, input bit dreq, input logic [31:0] ia, input logic [31:0] da,
                       input bit aok, input bit dok, input logic [31:0] rd,
                       output bit acc_i, output bit acc_d);
    exp_t e;
    ret_t r;
    int   who;
    bit   who_req, grant, acc;
    @(posedge clk); #1;
    inst_req   = ireq;  inst_addr = ia;  inst_wr = 1'b0; inst_size = 2'd2;
    inst_wstrb = 4'hf;  inst_wdata = i_wdata_h;
    data_req   = dreq;  data_addr = da;  data_wr = d_wr_h; data_size = d_size_h;
    data_wstrb = d_wstrb_h; data_wdata = d_wdata_h;
    bus_addr_ok = aok; bus_data_ok = dok; bus_rdata = rd;

    if (lock_who != 0) who = lock_who;
    else               who = dreq ? 2 : (ireq ? 1 : 0);
    who_req = (who == 2) ? dreq : ((who == 1) ? ireq : 1'b0);
    grant   = (oq.size() < DEPTH) && who_req;
    acc     = grant && aok;

    e.iaok = acc && (who == 1);
    e.daok = acc && (who == 2);
    e.breq = grant;
    e.bwr    = (who == 2) ? d_wr_h    : 1'b0;
    e.bsize  = (who == 2) ? d_size_h  : 2'd2;
    e.bwstrb = (who == 2) ? d_wstrb_h : 4'hf;
    e.baddr  = (who == 2) ? da        : ia;
    e.bwdata = (who == 2) ? d_wdata_h : i_wdata_h;
    e.cnt = oq.size();
    e.err = err_m;
    exp_q.push_back(e);

    if (dok) begin
      if (oq.size() > 0) begin
        r.is_data = oq.pop_front();
        r.rdata   = rd;
        ret_q.push_back(r);
      end else begin
        err_m = 1'b1;
      end
    end
    if (acc) oq.push_back(who == 2);
    lock_who = (grant && !acc) ? who : 0;
    acc_i = e.iaok;
    acc_d = e.daok;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = 4'hf; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wstrb = 4'hf; data_wdata = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
  endtask

  task automatic drain();
    bit a, b;
    int guard = 0;
    while (oq.size() > 0 && guard < 50) begin
      cycle(0, 0, '0, '0, 0, 1, $urandom, a, b);
      guard++;
    end
    if (oq.size() > 0) check("drain_timeout", oq.size(), 0);
  endtask

  // Monitor: compares every presented cycle and every returned data_ok
  always @(negedge clk) begin
    exp_t e;
    ret_t r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("inst_addr_ok", inst_addr_ok, e.iaok);
      check("data_addr_ok", data_addr_ok, e.daok);
      check("bus_req", bus_req, e.breq);
      check("outs_cnt", outs_cnt, e.cnt);
      check("err_unexp", err_unexp, e.err);
      if (e.breq) begin
        check("bus_addr", bus_addr, e.baddr);
        check("bus_fields", {bus_wr, bus_size, bus_wstrb}, {e.bwr, e.bsize, e.bwstrb});
        check("bus_wdata", bus_wdata, e.bwdata);
      end
    end
    if (inst_data_ok || data_data_ok) begin
      if (ret_q.size() == 0) begin
        check("unexpected_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      end else begin
        r = ret_q.pop_front();
        check("ret_owner", {inst_data_ok, data_data_ok}, r.is_data ? 2'b01 : 2'b10);
        check("ret_rdata", r.is_data ? data_rdata : inst_rdata, r.rdata);
        check("ret_other_rdata", r.is_data ? inst_rdata : data_rdata, 32'h0);
      end
    end
  end

  initial begin
    bit ai, ad, ir, dr, ip, dp;
    logic [31:0] ia, da;
    lock_who = 0; err_m = 0;
    i_wdata_h = 32'h1111_0000; d_wr_h = 0; d_size_h = 2'd2; d_wstrb_h = 4'hf; d_wdata_h = 32'h2222_0000;
    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs_cnt", outs_cnt, 0);
    check("rst_err", err_unexp, 0);
    check("rst_bus_req", bus_req, 0);
    reset = 1;

    // 1: data priority
    cycle(1, 1, 32'h0000_1000, 32'h0000_2000, 1, 0, 0, ai, ad);
    cycle(0, 0, 0, 0, 0, 1, 32'h1234_5678, ai, ad);
    cycle(0, 0, 0, 0, 0, 0, 0, ai, ad);

    // 2: lock holds IF address while MEM waits
    cycle(1, 0, 32'h0000_3000, 32'h0000_4000, 0, 0, 0, ai, ad);
    cycle(1, 1, 32'h0000_3000, 32'h0000_4000, 0, 0, 0, ai, ad);
    cycle(1, 1, 32'h0000_3000, 32'h0000_4000, 0, 0, 0, ai, ad);
    cycle(1, 1, 32'h0000_3000, 32'h0000_4000, 1, 0, 0, ai, ad);
    cycle(0, 1, 32'h0000_3000, 32'h0000_4000, 1, 0, 0, ai, ad);
    drain();

    // 3: ordering
    d_wr_h = 1; d_size_h = 2'd1; d_wstrb_h = 4'h3; d_wdata_h = 32'hCAFE_0001;
    cycle(1, 0, 32'h100, 0, 1, 0, 0, ai, ad);
    cycle(0, 1, 0, 32'h200, 1, 0, 0, ai, ad);
    cycle(1, 0, 32'h104, 0, 1, 0, 0, ai, ad);
    cycle(0, 0, 0, 0, 0, 1, 32'hA, ai, ad);
    cycle(0, 0, 0, 0, 0, 1, 32'hB, ai, ad);
    cycle(0, 0, 0, 0, 0, 1, 32'hC, ai, ad);

    // 4: full suppresses requests, reasserts the cycle after a pop
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 32'h300 + 4*k, 1, 0, 0, ai, ad);
    cycle(1, 1, 32'h500, 32'h600, 1, 0, 0, ai, ad);
    cycle(1, 1, 32'h500, 32'h600, 1, 1, 32'h77, ai, ad);
    cycle(1, 1, 32'h500, 32'h600, 1, 0, 0, ai, ad);
    drain();

    // 5: simultaneous push and pop at count 2
    cycle(1, 0, 32'h700, 0, 1, 0, 0, ai, ad);
    cycle(0, 1, 0, 32'h704, 1, 0, 0, ai, ad);
    cycle(1, 0, 32'h708, 0, 1, 1, 32'h55, ai, ad);
    cycle(0, 0, 0, 0, 0, 0, 0, ai, ad);
    drain();

    // 6: reset mid-burst then a stray return
    for (int k = 0; k < 3; k++) cycle(k[0], !k[0], 32'h800, 32'h900, 1, 0, 0, ai, ad);
    @(posedge clk); #1;
    inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
    reset = 0;
    #1;
    check("midrst_outs_cnt", outs_cnt, 0);
    check("midrst_bus_req", bus_req, 0);
    check("midrst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0);
    check("midrst_err", err_unexp, 0);
    oq.delete(); lock_who = 0; err_m = 0;
    @(posedge clk); #1;
    idle_inputs();
    reset = 1;
    cycle(0, 0, 0, 0, 0, 1, 32'hDEAD, ai, ad);
    cycle(0, 0, 0, 0, 0, 0, 0, ai, ad);

    // Random traffic; requesters hold their request until accepted
    ir = 0; dr = 0; ip = 0; dp = 0; ia = 0; da = 0;
    repeat (1500) begin
      if (!ip) begin ir = ($urandom_range(0, 2) != 0); ia = $urandom; i_wdata_h = $urandom; end
      if (!dp) begin
        dr = ($urandom_range(0, 2) != 0); da = $urandom;
        d_wr_h = $urandom_range(0, 1); d_size_h = 2'($urandom_range(0, 2));
        d_wstrb_h = 4'($urandom); d_wdata_h = $urandom;
      end
      cycle(ir, dr, ia, da, $urandom_range(0, 1) == 1,
            (oq.size() > 0) && ($urandom_range(0, 2) == 0), $urandom, ai, ad);
      ip = ir && !ai;
      dp = dr && !ad;
    end
    drain();
    cycle(0, 0, 0, 0, 0, 0, 0, ai, ad);
    @(posedge clk); #6;
    check("returns_left", ret_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester (IF stage) and the data requester (MEM-stage load/store path).
- Arbitrates address phases with data priority and a lock-until-accepted rule.
- Records the owner of every accepted transaction in an in-order FIFO, then routes each returning data_ok/rdata to that owner.
- Sits between the pipeline stages and the memory bridge; the pipeline derives stage ready_go from the per-side addr_ok/data_ok.

Parameters:
- OUTS_DEPTH, 4: maximum outstanding accepted-but-not-returned transactions; power of two, 2..16.
- OUTS_AW, 2: log2(OUTS_DEPTH), the owner-FIFO pointer width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst_req  in  1  IF request valid.
- inst_wr  in  1  IF write flag; IF always drives 0, passed through unchanged.
- inst_size  in  2  access size: 0=byte, 1=half, 2=word.
- inst_addr  in  32  IF address.
- inst_wstrb  in  4  IF byte enables.
- inst_wdata  in  32  IF write data.
- inst_addr_ok  out  1  IF address phase accepted this cycle.
- inst_data_ok  out  1  IF data returned this cycle.
- inst_rdata  out  32  IF read data.
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  MEM-side request, same meanings as the inst_* inputs.
- data_addr_ok  out  1  MEM address phase accepted this cycle.
- data_data_ok  out  1  MEM data or write-ack returned this cycle.
- data_rdata  out  32  MEM read data.
- bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata  out  1/1/2/32/4/32  shared port request.
- bus_addr_ok  in  1  shared port accepted the address phase.
- bus_data_ok  in  1  shared port returns data or write-ack.
- bus_rdata  in  32  shared port read data.
- outs_cnt  out  OUTS_AW+1  current outstanding count.
- err_unexp  out  1  sticky: bus_data_ok arrived with an empty owner FIFO.

Behaviour:
- Arbiter FSM states:
  - IDLE: no request presented on the bus.
  - LOCK_I: the IF request is presented and not yet accepted.
  - LOCK_D: the MEM request is presented and not yet accepted.
- full = (outs_cnt == OUTS_DEPTH). The effective request is suppressed while full, independent of pop in the same cycle (no bypass).
- Owner selection, combinational:
  - In IDLE, the owner is D if data_req, else I if inst_req.
  - In LOCK_x, the owner is x regardless of the other side's req, so the bus fields stay stable until acceptance.
- bus_req = !full && owner_req. The bus_* fields mux from the owner. When bus_req=0, the fields are don't-care; drive them from the data side.
- Transaction acceptance, acc = bus_req && bus_addr_ok:
  - The owner's *_addr_ok = acc. The other side's addr_ok = 0.
  - Push the owner bit into the FIFO (1 = D).
- FSM transitions:
  - Next state = IDLE if acc or !bus_req.
  - Otherwise next state = LOCK_I or LOCK_D according to the owner.
  - A requester deasserting req while locked is a protocol violation; the FSM returns to IDLE on the next edge with no push.
- Zero-cycle path: a request can be presented and accepted in the cycle it is first raised (combinational path req -> bus_req -> addr_ok).
- Response routing, ret = bus_data_ok && !empty:
  - Head owner = D: data_data_ok = ret and data_rdata = bus_rdata.
  - Head owner = I: inst_data_ok = ret and inst_rdata = bus_rdata.
  - Pop on ret.
  - The non-owner's rdata is held at 0.
- Simultaneous push and pop: the pointers both advance and outs_cnt is unchanged. The pop uses the pre-push head, so a transaction can never satisfy its own data_ok in its acceptance cycle.
- bus_data_ok with an empty FIFO: ignored for routing and sets err_unexp (sticky until reset).
- Pointers wrap modulo OUTS_DEPTH. outs_cnt is OUTS_AW+1 bits wide, saturating at neither end; a legal bus cannot overflow it.
- Reset (asynchronous, active-low), forced immediately:
  - state = IDLE, pointers = 0, outs_cnt = 0, err_unexp = 0.
  - All *_ok outputs and bus_req are 0 while reset is low, since req gating is on the reset state.
  - Reset mid-transaction discards the FIFO contents; later stale bus_data_ok pulses set err_unexp.
- Latency: the arbiter adds 0 cycles on both the address and data paths; all routing is combinational from registered FIFO state.

Test Plan:
1. Data priority:
   - Stimulus: inst_req=1 and data_req=1 together, bus_addr_ok=1, then bus_data_ok one cycle later with rdata=0x1234_5678.
   - Required: data_addr_ok=1 and inst_addr_ok=0 in the first cycle; then data_data_ok=1, data_rdata=0x12345678, outs_cnt 1 -> 0.
2. Lock:
   - Stimulus: inst_req alone with bus_addr_ok=0 for 3 cycles; data_req rises in cycle 2; bus_addr_ok=1 in cycle 4.
   - Required: bus_addr holds the inst address throughout; inst_addr_ok pulses in cycle 4; the data request is granted in cycle 5.
3. Ordering:
   - Stimulus: accept I (addr 0x100), D (0x200), I (0x104) back-to-back, then three bus_data_ok with rdata 0xA, 0xB, 0xC.
   - Required: inst gets 0xA, data gets 0xB, inst gets 0xC, in that order.
4. Full:
   - Stimulus: accept 4 requests with no returns.
   - Required: outs_cnt=4 and bus_req=0 despite a pending req. One bus_data_ok lowers the count to 3, and bus_req reasserts the following cycle.
5. Simultaneous push and pop:
   - Stimulus: with outs_cnt=2, acc and ret occur in the same cycle.
   - Required: outs_cnt stays 2 and the popped owner is the older entry.
6. Reset:
   - Stimulus: reset asserted low mid-burst with outs_cnt=3, then released, then a stray bus_data_ok.
   - Required: outs_cnt=0 and state IDLE immediately; after release, no *_data_ok pulse and err_unexp=1.
